// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word with a valid/ready
// handshake and shifts it out one bit per clock, with back-to-back frame support.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_shreg, w_shreg_next;
  logic             r_sdo, w_sdo_next;
  logic             r_sdo_valid, w_sdo_valid_next;

  logic             w_last;
  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_shreg_shifted;

  // The first bit leaves straight from load_data; the shift register keeps only the rest.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit     = load_data[WIDTH-1];
      assign w_load_rest     = load_data << 1;
      assign w_next_bit      = r_shreg[WIDTH-1];
      assign w_shreg_shifted = r_shreg << 1;
    end else begin : g_lsb_first
      assign w_first_bit     = load_data[0];
      assign w_load_rest     = load_data >> 1;
      assign w_next_bit      = r_shreg[0];
      assign w_shreg_shifted = r_shreg >> 1;
    end
  endgenerate

  assign w_last     = (r_state == SHIFT) && (r_cnt == LAST);
  assign load_ready = !rst && ((r_state == IDLE) || w_last);
  assign w_accept   = load_valid && load_ready;

  assign sdo       = r_sdo;
  assign sdo_valid = r_sdo_valid;
  assign busy      = r_sdo_valid;
  assign done      = r_sdo_valid && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_sdo       <= 1'b0;
      r_sdo_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shreg     <= w_shreg_next;
      r_sdo       <= w_sdo_next;
      r_sdo_valid <= w_sdo_valid_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_shreg_next     = r_shreg;
    w_sdo_next       = r_sdo;
    w_sdo_valid_next = r_sdo_valid;
    if (w_accept) begin
      // Acceptance in the last-bit cycle chains the next frame with no gap.
      w_state_next     = SHIFT;
      w_cnt_next       = '0;
      w_shreg_next     = w_load_rest;
      w_sdo_next       = w_first_bit;
      w_sdo_valid_next = 1'b1;
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        w_state_next     = IDLE;
        w_cnt_next       = '0;
        w_shreg_next     = '0;
        w_sdo_next       = 1'b0;
        w_sdo_valid_next = 1'b0;
      end else begin
        w_cnt_next       = r_cnt + CW'(1);
        w_shreg_next     = w_shreg_shifted;
        w_sdo_next       = w_next_bit;
        w_sdo_valid_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an LSB-first and an MSB-first instance share one stimulus.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] load_data;
  logic       load_valid;

  logic l_ready, l_sdo, l_valid, l_busy, l_done;
  logic m_ready, m_sdo, m_valid, m_busy, m_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] rx_l = '0;
  logic [3:0] rx_m = '0;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(l_ready), .sdo(l_sdo), .sdo_valid(l_valid), .busy(l_busy), .done(l_done)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_ready), .sdo(m_sdo), .sdo_valid(m_valid), .busy(m_busy), .done(m_done)
  );

  always #5 clk = ~clk;

  // Downstream serial-in shifters clocked on sdo_valid.
  always @(posedge clk) begin
    if (l_valid) rx_l <= {l_sdo, rx_l[3:1]};
    if (m_valid) rx_m <= {rx_m[2:0], m_sdo};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " sdo"}, 32'(l_sdo), 0);
    check({tag, " sdo_valid"}, 32'(l_valid), 0);
    check({tag, " busy"}, 32'(l_busy), 0);
    check({tag, " done"}, 32'(l_done), 0);
  endtask

  logic [3:0] exp_l, exp_m;
  logic [7:0] exp_seq;
  logic [3:0] word;

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0;
    step(); step();
    check_idle("reset");
    check("reset msb sdo_valid", 32'(m_valid), 0);
    check("reset load_ready", 32'(l_ready), 0);
    rst = 1'b0;
    #1;
    check("post-reset load_ready", 32'(l_ready), 1);

    // 4'b1011: LSB-first 1,1,0,1 ; MSB-first 1,0,1,1 (bit i = cycle i+1)
    exp_l = 4'b1011; exp_m = 4'b1101;
    load_data = 4'b1011; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b1011 lsb sdo[%0d]", i), 32'(l_sdo), 32'(exp_l[i]));
      check($sformatf("b1011 msb sdo[%0d]", i), 32'(m_sdo), 32'(exp_m[i]));
      check($sformatf("b1011 valid[%0d]", i), 32'(l_valid), 1);
      check($sformatf("b1011 busy[%0d]", i), 32'(l_busy), 1);
      check($sformatf("b1011 done[%0d]", i), 32'(l_done), 32'(i == 3));
      check($sformatf("b1011 ready[%0d]", i), 32'(l_ready), 32'(i == 3));
      step();
    end
    check_idle("after b1011");
    $display("frame 4'b1011 single transmitted");

    // Back-to-back 4'hA, 4'h5: 0,1,0,1,1,0,1,0
    exp_seq = 8'b01011010;
    load_data = 4'hA; load_valid = 1'b1;
    step();
    load_data = 4'h5;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b sdo[%0d]", i), 32'(l_sdo), 32'(exp_seq[i]));
      check($sformatf("b2b valid[%0d]", i), 32'(l_valid), 1);
      check($sformatf("b2b done[%0d]", i), 32'(l_done), 32'(i == 3 || i == 7));
      step();
      if (i == 3) load_valid = 1'b0;
    end
    check_idle("after b2b");
    $display("frames 4'hA,4'h5 back-to-back transmitted");

    // 4'b0110 with load_valid toggling mid-frame: 0,1,1,0
    exp_l = 4'b0110;
    load_data = 4'b0110; load_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      load_valid = (i < 3) && (i % 2 == 0);
      load_data  = 4'(9 + i);
      #1;
      check($sformatf("ignore sdo[%0d]", i), 32'(l_sdo), 32'(exp_l[i]));
      check($sformatf("ignore valid[%0d]", i), 32'(l_valid), 1);
      check($sformatf("ignore ready[%0d]", i), 32'(l_ready), 32'(i == 3));
      step();
    end
    check_idle("after ignore");
    $display("frame 4'b0110 with ignored loads transmitted");

    // Reset after bit 2 of 4'hF
    load_data = 4'hF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("abort sdo[0]", 32'(l_sdo), 1);
    step();
    check("abort sdo[1]", 32'(l_sdo), 1);
    rst = 1'b1;
    #1;
    check("abort ready in rst", 32'(l_ready), 0);
    step();
    check_idle("abort");
    // Load offered together with reset is dropped
    load_valid = 1'b1; load_data = 4'h7;
    step();
    check_idle("rst drops load");
    rst = 1'b0; load_valid = 1'b0;
    step();
    check_idle("rst drops load later");
    exp_l = 4'b1100;
    load_data = 4'b1100; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post-abort sdo[%0d]", i), 32'(l_sdo), 32'(exp_l[i]));
      check($sformatf("post-abort done[%0d]", i), 32'(l_done), 32'(i == 3));
      step();
    end
    check_idle("after post-abort");
    $display("frame 4'hF aborted by reset, 4'b1100 transmitted");

    // Loopback of random words
    for (int n = 0; n < 100; n++) begin
      word = 4'($urandom_range(0, 15));
      load_data = word; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      repeat (4) step();
      check($sformatf("loop lsb #%0d", n), 32'(rx_l), 32'(word));
      check($sformatf("loop msb #%0d", n), 32'(rx_m), 32'(word));
      $display("loopback word %0d = %h rx_lsb=%h rx_msb=%h", n, word, rx_l, rx_m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 transmits bit 0 first, 1 transmits bit WIDTH-1 first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port load_data, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port load_valid, input, 1 bit: load_data is offered this cycle.
REQ-007 SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 SHALL have port sdo, output, 1 bit: serial data out, registered.
REQ-009 SHALL have port sdo_valid, output, 1 bit: sdo carries a frame bit this cycle, registered.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress (equal to sdo_valid).
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse coincident with the last bit of a frame.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 SHALL accept a word on a rising edge where load_valid=1 and load_ready=1; no other condition loads the shift register.
REQ-014 SHALL drive load_ready=1 in IDLE, and in SHIFT only during the last-bit cycle (bit counter = WIDTH-1); 0 otherwise.
REQ-015 SHALL present the first frame bit on sdo with sdo_valid=1 in the cycle after acceptance (latency 1 clock).
REQ-016 SHALL present WIDTH consecutive bits, one per clock, with sdo_valid=1 for exactly WIDTH cycles per frame.
REQ-017 SHALL use bit order per MSB_FIRST; with MSB_FIRST=0, a downstream serial-in shifter that shifts toward bit 0 holds load_data exactly after WIDTH bits.
REQ-018 SHALL keep a bit counter of ceil(log2(WIDTH)) bits that counts 0..WIDTH-1 during SHIFT and clears on acceptance; no wrap past WIDTH-1.
REQ-019 SHALL assert done=1 in the cycle where the counter is WIDTH-1 and sdo_valid=1, and done=0 in all other cycles.
REQ-020 SHALL, on acceptance during the last-bit cycle, go directly to the new frame: its first bit follows the previous last bit with no gap, and sdo_valid stays 1.
REQ-021 SHALL return to IDLE after the last bit when no word is accepted, with sdo_valid=0 and sdo=0 in the next cycle.
REQ-022 SHALL ignore load_valid and load_data changes while load_ready=0; the frame in flight is not disturbed.
REQ-023 SHALL hold sdo=0 whenever sdo_valid=0.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, force state=IDLE, counter=0, shift register=0, sdo=0, sdo_valid=0, busy=0, done=0.
REQ-025 SHALL drive load_ready=0 while rst=1, and 1 from the first cycle after rst deasserts.
REQ-026 SHALL give rst priority over a simultaneous load; a word offered with rst=1 is dropped.
REQ-027 SHALL abort any frame in progress when rst is asserted mid-frame, without a done pulse; no partial bits are emitted after reset.

Verification
REQ-028 Bench SHALL cover: WIDTH=4, MSB_FIRST=0, load 4'b1011 from IDLE -> sdo = 1,1,0,1 on cycles 1..4 after acceptance, sdo_valid high for 4 cycles, done only on cycle 4.
REQ-029 Bench SHALL cover: MSB_FIRST=1, load 4'b1011 -> sdo = 1,0,1,1.
REQ-030 Bench SHALL cover: back-to-back 4'hA then 4'h5 with load_valid held -> 8 contiguous valid bits 0,1,0,1,1,0,1,0, and two done pulses 4 cycles apart.
REQ-031 Bench SHALL cover: load_valid toggled with new data during bits 1..3 of a frame -> output unchanged, load_ready=0 on those cycles.
REQ-032 Bench SHALL cover: rst asserted after bit 2 of 4'hF -> next cycle sdo=0, sdo_valid=0, no done; next load transmits correctly.
REQ-033 Bench SHALL cover: loopback into a 4-bit serial-in shifter clocked on sdo_valid -> shifter holds the loaded word after each frame, for 100 random words.
